// File: rtl/mem_swap_ctrl.sv
// Swaps an address range between two single-port memories A and B, one word per
// READ/WRITE pair; while idle, passes an external access port through to A or B.
module mem_swap_ctrl #(
  parameter int addr_w_N    = 7,
  parameter int data_w_Bits = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [addr_w_N-1:0]    lo_addr,
  input  logic [addr_w_N-1:0]    hi_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [addr_w_N:0]      swap_count,
  input  logic                   ext_sel,
  input  logic                   ext_we,
  input  logic [addr_w_N-1:0]    ext_addr,
  input  logic [data_w_Bits-1:0] ext_data_w,
  output logic [data_w_Bits-1:0] ext_data_r,
  output logic [addr_w_N-1:0]    a_addr,
  output logic [addr_w_N-1:0]    b_addr,
  output logic                   a_we,
  output logic                   b_we,
  output logic [data_w_Bits-1:0] a_data_w,
  output logic [data_w_Bits-1:0] b_data_w,
  input  logic [data_w_Bits-1:0] a_data_r,
  input  logic [data_w_Bits-1:0] b_data_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [addr_w_N-1:0]    CUR_ONE   = {{(addr_w_N-1){1'b0}}, 1'b1};
  localparam logic [addr_w_N:0]      CNT_ONE   = {{addr_w_N{1'b0}}, 1'b1};
  localparam logic [data_w_Bits-1:0] DATA_ZERO = {data_w_Bits{1'b0}};

  state_t                r_state;
  state_t                w_next;
  logic                  w_abort_flag;
  logic [addr_w_N-1:0]   r_cur;
  logic [addr_w_N-1:0]   r_hi;
  logic [addr_w_N:0]     r_count;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; the last-word test has priority so abort on the final WRITE is not flagged
  always_comb begin
    w_next       = r_state;
    w_abort_flag = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (lo_addr <= hi_addr) ? S_READ : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ: begin
        if (abort) begin
          w_next       = S_DONE;
          w_abort_flag = 1'b1;
        end else begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_cur == r_hi) begin
          w_next = S_DONE;
        end else if (abort) begin
          w_next       = S_DONE;
          w_abort_flag = 1'b1;
        end else begin
          w_next = S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address counter, word count and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur     <= {addr_w_N{1'b0}};
      r_hi      <= {addr_w_N{1'b0}};
      r_count   <= {(addr_w_N+1){1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_aborted <= w_abort_flag;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur   <= lo_addr;
            r_hi    <= hi_addr;
            r_count <= {(addr_w_N+1){1'b0}};
          end
        end
        S_WRITE: begin
          r_count <= r_count + CNT_ONE;
          if (w_next == S_READ) begin
            r_cur <= r_cur + CUR_ONE;
          end
        end
        default: begin
          r_cur <= r_cur;
        end
      endcase
    end
  end

  // Memory pin mux: external port in IDLE, swap sequencer otherwise
  always_comb begin
    a_addr     = ext_addr;
    b_addr     = ext_addr;
    a_we       = 1'b0;
    b_we       = 1'b0;
    a_data_w   = DATA_ZERO;
    b_data_w   = DATA_ZERO;
    ext_data_r = DATA_ZERO;
    case (r_state)
      S_IDLE: begin
        if (ext_sel) begin
          b_we       = ext_we;
          b_data_w   = ext_data_w;
          ext_data_r = b_data_r;
        end else begin
          a_we       = ext_we;
          a_data_w   = ext_data_w;
          ext_data_r = a_data_r;
        end
      end
      S_READ: begin
        a_addr = r_cur;
        b_addr = r_cur;
      end
      S_WRITE: begin
        a_addr   = r_cur;
        b_addr   = r_cur;
        a_we     = 1'b1;
        b_we     = 1'b1;
        a_data_w = b_data_r;
        b_data_w = a_data_r;
      end
      S_DONE: begin
        a_addr = r_cur;
        b_addr = r_cur;
      end
      default: begin
        a_we = 1'b0;
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign swap_count = r_count;

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// Self-checking bench for mem_swap_ctrl: behavioural A/B memories, a reference
// copy of their contents, and a scoreboard of expected swap results.
module tb_mem_swap_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [AW-1:0] lo_addr, hi_addr;
  logic          busy, done, aborted;
  logic [AW:0]   swap_count;
  logic          ext_sel, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data_w, ext_data_r;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_we, b_we;
  logic [DW-1:0] a_data_w, b_data_w, a_data_r, b_data_r;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] ref_a [DEPTH];
  logic [DW-1:0] ref_b [DEPTH];

  typedef struct {
    int count;
    bit ab;
    int lat;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  mem_swap_ctrl #(.addr_w_N(AW), .data_w_Bits(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_addr(lo_addr), .hi_addr(hi_addr),
    .busy(busy), .done(done), .aborted(aborted), .swap_count(swap_count),
    .ext_sel(ext_sel), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data_w(ext_data_w), .ext_data_r(ext_data_r),
    .a_addr(a_addr), .b_addr(b_addr), .a_we(a_we), .b_we(b_we),
    .a_data_w(a_data_w), .b_data_w(b_data_w),
    .a_data_r(a_data_r), .b_data_r(b_data_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_data_w;
    a_data_r <= mem_a[a_addr];
  end

  always @(posedge clk) begin
    if (b_we) mem_b[b_addr] <= b_data_w;
    b_data_r <= mem_b[b_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({busy, done, aborted} !== 3'b000 || swap_count !== '0) begin
      n_errors++;
      $display("FAIL reset_state: busy/done/aborted=%b%b%b swap_count=%0d, want 000 and 0",
               busy, done, aborted, swap_count);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic preload;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        ext_sel    = s[0];
        ext_we     = 1'b1;
        ext_addr   = AW'(i);
        ext_data_w = (s == 0) ? DW'(i) : DW'(8'h80 + i);
        if (s == 0) ref_a[i] = ext_data_w;
        else        ref_b[i] = ext_data_w;
        tick;
      end
    end
    ext_we = 1'b0;
  endtask

  task automatic verify_mem(input string name);
    logic [DW-1:0] want;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        ext_sel  = s[0];
        ext_we   = 1'b0;
        ext_addr = AW'(i);
        tick;
        want = (s == 0) ? ref_a[i] : ref_b[i];
        n_checks++;
        if (ext_data_r !== want) begin
          n_errors++;
          $display("FAIL %s_mem%s[%0d]: got %h want %h", name, (s == 0) ? "A" : "B", i, ext_data_r, want);
        end
      end
    end
  endtask

  task automatic run_swap(input int lo, input int hi, input int abort_rd, input string name);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    n = (hi >= lo) ? hi - lo + 1 : 0;
    if (abort_rd > 0 && abort_rd <= n) begin
      e.count = abort_rd - 1;
      e.ab    = 1'b1;
      e.lat   = 2 * (abort_rd - 1) + 1;
    end else begin
      e.count = n;
      e.ab    = 1'b0;
      e.lat   = 2 * n;
    end
    sb_q.push_back(e);
    for (int i = lo; i < lo + e.count; i++) begin
      logic [DW-1:0] t;
      t        = ref_a[i];
      ref_a[i] = ref_b[i];
      ref_b[i] = t;
    end

    ext_we  = 1'b0;
    lo_addr = AW'(lo);
    hi_addr = AW'(hi);
    start   = 1'b1;
    tick;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 400) begin
      abort      = (abort_rd > 0 && lat == 2 * (abort_rd - 1));
      ext_we     = 1'b1;
      ext_sel    = $urandom_range(0, 1);
      ext_addr   = AW'($urandom_range(0, DEPTH - 1));
      ext_data_w = 8'hEE;
      n_checks++;
      if (busy !== 1'b1 || ext_data_r !== 8'h00) begin
        n_errors++;
        $display("FAIL %s_busy_phase: busy=%b ext_data_r=%h at cycle %0d, want 1 and 00",
                 name, busy, ext_data_r, lat + 1);
      end
      tick;
      lat++;
    end
    abort  = 1'b0;
    ext_we = 1'b0;

    got = sb_q.pop_front();
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, want at %0d", name, lat, got.lat);
    end else begin
      if (lat !== got.lat || int'(swap_count) !== got.count || aborted !== got.ab || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_done: lat=%0d count=%0d aborted=%b busy=%b, want lat=%0d count=%0d aborted=%b busy=1",
                 name, lat, swap_count, aborted, busy, got.lat, got.count, got.ab);
      end
      tick;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || int'(swap_count) !== got.count) begin
        n_errors++;
        $display("FAIL %s_after_done: busy=%b done=%b aborted=%b count=%0d, want 0 0 0 %0d",
                 name, busy, done, aborted, swap_count, got.count);
      end
    end
  endtask

  task automatic test_ext_access;
    ext_sel    = 1'b1;
    ext_we     = 1'b1;
    ext_addr   = 7'd20;
    ext_data_w = 8'hAA;
    ref_b[20]  = 8'hAA;
    tick;
    ext_we = 1'b0;
    tick;
    n_checks++;
    if (ext_data_r !== 8'hAA) begin
      n_errors++;
      $display("FAIL ext_read_B20: got %h want aa", ext_data_r);
    end
    ext_sel = 1'b0;
    tick;
    n_checks++;
    if (ext_data_r !== ref_a[20]) begin
      n_errors++;
      $display("FAIL ext_read_A20: got %h want %h", ext_data_r, ref_a[20]);
    end
  endtask

  task automatic test_reset_mid_swap;
    ext_we  = 1'b0;
    lo_addr = 7'd0;
    hi_addr = 7'd5;
    start   = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, aborted, a_we, b_we} !== 5'b00000 || swap_count !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_swap: busy=%b done=%b aborted=%b a_we=%b b_we=%b count=%0d, want all 0",
               busy, done, aborted, a_we, b_we, swap_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] t;
      t        = ref_a[i];
      ref_a[i] = ref_b[i];
      ref_b[i] = t;
    end
    tick;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_swap_idle: busy=%b want 0", busy);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    lo_addr    = '0;
    hi_addr    = '0;
    ext_sel    = 1'b0;
    ext_we     = 1'b0;
    ext_addr   = '0;
    ext_data_w = '0;

    test_reset;
    preload;
    verify_mem("preload");
    run_swap(3, 5, 0, "basic_3_5");
    verify_mem("basic_3_5");
    run_swap(10, 10, 0, "single_10");
    run_swap(9, 4, 0, "empty_9_4");
    verify_mem("single_empty");
    run_swap(0, 7, 2, "abort_0_7");
    verify_mem("abort_0_7");
    run_swap(0, 127, 0, "full_range");
    verify_mem("full_range");
    run_swap(20, 30, 7, "abort_20_30");
    test_ext_access;
    test_reset_mid_swap;
    verify_mem("reset_mid_swap");
    run_swap(40, 45, 0, "after_reset");
    run_swap(120, 127, 0, "top_range");
    verify_mem("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
